// File: rtl/alu_slice_seq.sv
// Slice-serial AND/OR/ADD/SUB unit: WIDTH-bit operands, SLICE bits per clock, valid/ready on both sides.
// Optional status flags {zero, negative, overflow} are built only when ALU_FLAGS_EN is defined.
module alu_slice_seq #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout
`ifdef ALU_FLAGS_EN
  ,
  output logic [2:0]       flags
`endif
);

  localparam int N  = WIDTH / SLICE;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b11;

  localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({SLICE{1'b1}});

  logic [1:0]       r_state;
  logic [1:0]       w_state_next;
  logic [KW-1:0]    r_k;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [1:0]       r_op;
  logic             r_carry;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic             r_in_ready;
  logic             r_out_valid;

  logic             w_accept;
  logic             w_last;
  logic             w_arith;
  logic [31:0]      w_base;
  logic [SLICE-1:0] w_a_s;
  logic [SLICE-1:0] w_b_s;
  logic [SLICE-1:0] w_b_eff;
  logic [SLICE:0]   w_sum;
  logic [SLICE-1:0] w_slice;
  logic             w_carry_out;
  logic [WIDTH-1:0] w_result_next;

  assign w_accept = (r_state == S_IDLE) && in_valid && r_in_ready;
  assign w_last   = (r_k == KW'(N - 1));
  assign w_arith  = r_op[1];
  assign w_base   = 32'(r_k) * 32'(SLICE);

  assign w_a_s   = SLICE'(r_a >> w_base);
  assign w_b_s   = SLICE'(r_b >> w_base);
  assign w_b_eff = (r_op == OP_SUB) ? ~w_b_s : w_b_s;
  assign w_sum   = {1'b0, w_a_s} + {1'b0, w_b_eff} + {{SLICE{1'b0}}, r_carry};

  // NOTE: every always_comb output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_slice = w_sum[SLICE-1:0];
    case (r_op)
      OP_AND:  w_slice = w_a_s & w_b_s;
      OP_OR:   w_slice = w_a_s | w_b_s;
      default: w_slice = w_sum[SLICE-1:0];
    endcase
  end

  // Logic ops never propagate a carry between slices.
  assign w_carry_out   = w_arith & w_sum[SLICE];
  assign w_result_next = (r_result & ~(SLICE_MASK << w_base)) | (WIDTH'(w_slice) << w_base);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = S_BUSY;
      S_BUSY:  if (w_last) w_state_next = S_DONE;
      S_DONE:  if (out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

`ifdef ALU_FLAGS_EN
  logic [2:0] r_flags;
  logic       w_msb_cin;
  logic       w_ovf;

  // Carry into the MSB is recovered from the MSB sum bit of the last slice.
  assign w_msb_cin = w_a_s[SLICE-1] ^ w_b_eff[SLICE-1] ^ w_sum[SLICE-1];
  assign w_ovf     = w_arith & (w_msb_cin ^ w_sum[SLICE]);
  assign flags     = r_flags;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flags <= 3'b000;
    end else if (r_state == S_BUSY && w_last) begin
      r_flags <= {(w_result_next == '0), w_result_next[WIDTH-1], w_ovf};
    end
  end
`endif

  // NOTE: state and outputs use non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_carry     <= 1'b0;
      r_result    <= '0;
      r_cout      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_in_ready  <= (w_state_next == S_IDLE);
      r_out_valid <= (w_state_next == S_DONE);
      if (w_accept) begin
        r_k     <= '0;
        r_carry <= cin;
      end else if (r_state == S_BUSY) begin
        r_result <= w_result_next;
        r_carry  <= w_carry_out;
        r_k      <= r_k + KW'(1);
        if (w_last) r_cout <= w_carry_out;
      end
    end
  end

  // NOTE: captured operands need no reset; they are always loaded before being read.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a  <= op_a;
      r_b  <= op_b;
      r_op <= op;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign cout      = r_cout;

endmodule
